// File: rtl/proj_fluxo_fila_pkg.sv
// proj_fluxo_fila_pkg: FSM state encoding and default parameter constants shared by the block
package proj_fluxo_fila_pkg;
    typedef enum logic [1:0] {OCIOSO, ATIVO, COMPARA, FIM} estado_t;
    localparam int COORD_W_PAD = 3;
    localparam int DEPTH_PAD = 4;
    localparam int T_MAX_PAD = 30000;
    localparam int T_PENAL_PAD = 1000;
    localparam int PTS_W_PAD = 8;
endpackage

// File: rtl/fila_jogadas.sv
// fila_jogadas: expected-move FIFO; a push while full only succeeds if a pop happens in the same cycle
module fila_jogadas
    import proj_fluxo_fila_pkg::*;
#(
    parameter int COORD_W = COORD_W_PAD,
    parameter int DEPTH = DEPTH_PAD
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [COORD_W-1:0]           linha_in,
    input  logic [COORD_W-1:0]           coluna_in,
    output logic [COORD_W-1:0]           linha_out,
    output logic [COORD_W-1:0]           coluna_out,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [2*COORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    always_comb begin
        empty = count == '0;
        full = count == CW'(DEPTH);
        do_pop = pop & ~empty;
        do_push = push & (~full | do_pop);
        {linha_out, coluna_out} = empty ? '0 : mem[rd];
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr] <= {linha_in, coluna_in};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/proj_fluxo_fila.sv
// proj_fluxo_fila: timed move-matching round against a queue of expected moves, with score and penalties
module proj_fluxo_fila
    import proj_fluxo_fila_pkg::*;
#(
    parameter int COORD_W = COORD_W_PAD,
    parameter int DEPTH = DEPTH_PAD,
    parameter int T_MAX = T_MAX_PAD,
    parameter int T_PENAL = T_PENAL_PAD,
    parameter int PTS_W = PTS_W_PAD
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inicia,
    input  logic                         carrega,
    input  logic [COORD_W-1:0]           linhaNova,
    input  logic [COORD_W-1:0]           colunaNova,
    input  logic                         jogou,
    input  logic [COORD_W-1:0]           jogadaLinha,
    input  logic [COORD_W-1:0]           jogadaColuna,
    output logic [COORD_W-1:0]           linhaEsperada,
    output logic [COORD_W-1:0]           colunaEsperada,
    output logic                         acertou,
    output logic                         errou,
    output logic                         fimT,
    output logic [$clog2(T_MAX+1)-1:0]   tempo,
    output logic [PTS_W-1:0]             pontos,
    output logic                         vazia,
    output logic                         cheia,
    output logic [$clog2(DEPTH+1)-1:0]   ocupacao,
    output logic                         estourou
);
    localparam int TW = $clog2(T_MAX+1);
    // Penalty clamped to T_MAX so penalty+tick always fits in TW+1 bits
    localparam logic [TW:0] PENAL = (T_PENAL > T_MAX) ? (TW+1)'(T_MAX) : (TW+1)'(T_PENAL);
    estado_t estado, estado_prox;
    logic jogou_q, borda, acerto, erro, ativo, aceita, reinicia;
    logic [COORD_W-1:0] lat_linha, lat_coluna;
    logic [TW:0] dec;
    logic [TW-1:0] tempo_prox;

    fila_jogadas #(.COORD_W(COORD_W), .DEPTH(DEPTH)) u_fila (
        .clock(clock),
        .reset(reset),
        .push(carrega),
        .pop(acerto),
        .linha_in(linhaNova),
        .coluna_in(colunaNova),
        .linha_out(linhaEsperada),
        .coluna_out(colunaEsperada),
        .full(cheia),
        .empty(vazia),
        .count(ocupacao)
    );

    always_comb begin
        borda = jogou & ~jogou_q;
        ativo = estado == ATIVO || estado == COMPARA;
        acerto = estado == COMPARA && !vazia && lat_linha == linhaEsperada && lat_coluna == colunaEsperada;
        erro = estado == COMPARA && !acerto;
        dec = erro ? PENAL + 1'b1 : (TW+1)'(1);
        tempo_prox = ({1'b0, tempo} > dec) ? TW'({1'b0, tempo} - dec) : '0;
        aceita = estado == ATIVO && borda && !vazia && tempo_prox != '0;
        reinicia = (estado == OCIOSO || estado == FIM) && inicia;
        estado_prox = reinicia ? ATIVO : !ativo ? estado : tempo_prox == '0 ? FIM : aceita ? COMPARA : ATIVO;
        fimT = estado == FIM;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
            jogou_q <= 1'b0;
            lat_linha <= '0;
            lat_coluna <= '0;
            acertou <= 1'b0;
            errou <= 1'b0;
            tempo <= TW'(T_MAX);
            pontos <= '0;
            estourou <= 1'b0;
        end else begin
            estado <= estado_prox;
            jogou_q <= jogou;
            acertou <= acerto;
            errou <= erro;
            if (aceita) begin
                lat_linha <= jogadaLinha;
                lat_coluna <= jogadaColuna;
            end
            tempo <= reinicia ? TW'(T_MAX) : ativo ? tempo_prox : tempo;
            pontos <= reinicia ? '0 : (acerto && pontos != '1) ? pontos + 1'b1 : pontos;
            estourou <= estourou | (carrega & cheia & ~acerto);
        end
    end
endmodule

// File: doc/proj_fluxo_fila.md
PROJ_FLUXO_FILA -- requirements
Module: proj_fluxo_fila

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning): COORD_W, 3, coordinate width; DEPTH, 4, expected-move queue depth (power of 2, at least 2); T_MAX, 30000, round length in clocks; T_PENAL, 1000, clocks removed per wrong move; PTS_W, 8, score width.
REQ-003 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- inicia  in  1  starts a round
- carrega  in  1  pushes (linhaNova, colunaNova) onto the queue
- linhaNova, colunaNova  in  COORD_W  expected move to push
- jogou  in  1  player level signal; a rising edge means a move is made
- jogadaLinha, jogadaColuna  in  COORD_W  player move
- linhaEsperada, colunaEsperada  out  COORD_W  queue head
- acertou, errou  out  1  one-cycle result pulses
- fimT  out  1  round over
- tempo  out  clog2(T_MAX+1)  remaining clocks
- pontos  out  PTS_W  score
- vazia, cheia  out  1  queue empty / full flags
- ocupacao  out  clog2(DEPTH+1)  number of queue entries
- estourou  out  1  sticky flag: a push was dropped

Function
REQ-004 FSM states SHALL be OCIOSO, ATIVO, COMPARA and FIM.
REQ-005 Transitions: OCIOSO->ATIVO on inicia; ATIVO->COMPARA on a jogou rising edge with the queue not empty; COMPARA->ATIVO after one cycle; ATIVO or COMPARA->FIM when tempo reaches 0; FIM->ATIVO on inicia.
REQ-006 Jogou edge detection SHALL use one registered sample of jogou: edge = jogou & ~jogou_q.
REQ-007 On an accepted edge, jogadaLinha and jogadaColuna SHALL be latched at that clock edge.
REQ-008 In the COMPARA cycle, both latched coordinates equal to the head SHALL produce a hit; any difference SHALL produce a miss.
REQ-009 The result SHALL take effect at the edge ending COMPARA, and acertou or errou SHALL then be high for exactly one cycle.
REQ-010 On a hit, the queue SHALL pop and pontos SHALL increment, saturating at 2^PTS_W-1.
REQ-011 On a miss, the queue SHALL NOT change and tempo SHALL decrease by T_PENAL, floored at 0.
REQ-012 Jogou edges in OCIOSO, in FIM, in COMPARA, or with the queue empty SHALL be ignored: no pulse and no state change.
REQ-013 tempo SHALL decrement by 1 per clock in ATIVO and COMPARA, and SHALL hold in OCIOSO and FIM.
REQ-014 If a penalty and a tick fall on the same cycle, tempo SHALL reduce by T_PENAL+1, floored at 0.
REQ-015 fimT SHALL be high exactly while in FIM.
REQ-016 inicia SHALL load tempo=T_MAX and clear pontos, and SHALL leave the queue contents unchanged.
REQ-017 carrega SHALL be honoured in every state.
REQ-018 When the queue is full, a push SHALL be dropped and estourou set, except when a hit pops in the same cycle; then both pop and push SHALL occur and ocupacao SHALL be unchanged.
REQ-019 A push to an empty queue SHALL appear on linhaEsperada/colunaEsperada in the next cycle.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 When the queue is empty, the head outputs SHALL read 0.

Reset
REQ-022 Reset SHALL take priority over all other inputs.
REQ-023 Reset values: state OCIOSO; tempo=T_MAX; pontos=0; queue empty; ocupacao=0; vazia=1; cheia=0; estourou=0; acertou=errou=fimT=0; jogou_q=0.
REQ-024 Reset asserted during COMPARA SHALL suppress that comparison's pulse and pop.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding and the default parameter constants.
REQ-026 The queue SHALL be a separate sub-module, fila_jogadas, parametrised by COORD_W and DEPTH, with push/pop/full/empty/count ports.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Reset, push (2,5), inicia, jogou edge with (2,5): acertou=1 for one cycle, pontos=1, vazia=1.
- Push (1,1), jogou edge with (1,2): errou=1, tempo drops by 1001 over that cycle, ocupacao stays 1.
- Push 5 entries with DEPTH=4: ocupacao=4, cheia=1, estourou=1; head equals the first entry pushed.
- Queue full, hit coinciding with carrega: ocupacao stays 4 and the new entry lands at the tail.
- T_MAX=20, T_PENAL=15, one miss at cycle 3: fimT rises by cycle 5, and later jogou edges give no pulses.
- pontos at 255 plus a hit: pontos stays 255; reset mid-COMPARA: no pulse, queue unchanged.
